// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: time-multiplexed 7-segment scan with blanking gaps and frame-boundary double buffering.
// Define SEG_SCAN_LEADING_ZERO_BLANK_EN to keep leading-zero digits dark.
module seg7_scan_controller #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_load_valid,
   input  logic [NUM_DIGITS*3-1:0] i_load_data,
   output logic                    o_load_ready,
   output logic [2:0]              o_digit_val,
   output logic [NUM_DIGITS-1:0]   o_digit_sel,
   output logic                    o_frame_done
);
   localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int DW = NUM_DIGITS * 3;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
   typedef enum logic {BLANK, DRIVE} state_t;
   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DW-1:0]         display_q, display_d, pending_q, pending_d;
   logic                  pend_full_q, pend_full_d;
   logic [2:0]            val_q, val_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic                  frame_done_q, frame_done_d;
   logic                  slot_end, last, boundary, accept, drive_en;
   always_comb begin
      slot_end     = cnt_q == ((state_q == BLANK) ? CW'(BLANK_CYCLES - 1) : CW'(REFRESH_DIV - 1));
      last         = idx_q == IW'(NUM_DIGITS - 1);
      boundary     = (state_q == DRIVE) && slot_end && last;
      accept       = i_load_valid && !pend_full_q;
      state_d      = slot_end ? ((state_q == BLANK) ? DRIVE : BLANK) : state_q;
      cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
      idx_d        = ((state_q == DRIVE) && slot_end) ? (last ? '0 : idx_q + IW'(1)) : idx_q;
      pending_d    = accept ? i_load_data : pending_q;
      display_d    = (boundary && pend_full_q) ? pending_q : display_q;
      pend_full_d  = accept ? 1'b1 : (boundary ? 1'b0 : pend_full_q);
      val_d        = display_d[3*int'(idx_d) +: 3];
      drive_en     = state_d == DRIVE;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      // Dark when this digit and every more-significant digit are zero; digit 0 always lit.
      drive_en     = drive_en && ((idx_d == '0) || ((display_d >> (3*int'(idx_d))) != '0));
`endif
      sel_d        = drive_en ? (SEL_OFF ^ (NUM_DIGITS'(1) << idx_d)) : SEL_OFF;
      frame_done_d = boundary;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= BLANK;
         idx_q        <= '0;
         cnt_q        <= '0;
         display_q    <= '0;
         pending_q    <= '0;
         pend_full_q  <= 1'b0;
         val_q        <= '0;
         sel_q        <= SEL_OFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         display_q    <= display_d;
         pending_q    <= pending_d;
         pend_full_q  <= pend_full_d;
         val_q        <= val_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_done_d;
      end
   end
   assign o_load_ready = ~pend_full_q;
   assign o_digit_val  = val_q;
   assign o_digit_sel  = sel_q;
   assign o_frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: randomized loads checked against a cycle-position reference model.
module tb_seg7_scan_controller;
   localparam int N = 4, R = 4, B = 1, SLOT = B + R, FRAME = N * SLOT;
   logic        clk = 1'b0, rst_n = 1'b1, valid = 1'b0;
   logic [11:0] data = '0;
   logic        ready, done;
   logic [2:0]  val;
   logic [3:0]  sel;
   int          checks = 0, failures = 0, k = 0;
   logic [11:0] m_disp = '0, m_pend = '0;
   logic        m_full = 1'b0;
   seg7_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .SEL_ACTIVE_LOW(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(valid), .i_load_data(data),
      .o_load_ready(ready), .o_digit_val(val), .o_digit_sel(sel), .o_frame_done(done));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask
   function automatic logic [3:0] exp_sel();
      int p = k % FRAME, d = p / SLOT;
      if (p % SLOT < B) return 4'hF;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      if (d > 0 && (m_disp >> (3*d)) == 0) return 4'hF;
`endif
      return ~(4'b0001 << d);
   endfunction
   function automatic logic [2:0] exp_val();
      int d = (k % FRAME) / SLOT;
      return 3'((m_disp >> (3*d)) & 12'o7);
   endfunction
   task automatic check_all();
      check("sel", sel, exp_sel());
      check("val", val, exp_val());
      check("ready", ready, !m_full);
      check("done", done, k > 0 && k % FRAME == 0);
   endtask
   task automatic tick();
      logic acc = valid && !m_full;
      @(posedge clk);
      k++;
      if (m_full && k % FRAME == 0) begin
         m_disp = m_pend;
         m_full = 1'b0;
      end
      if (acc) begin
         m_pend = data;
         m_full = 1'b1;
      end
      #1;
      check_all();
      if (acc) valid = 1'b0;
   endtask
   task automatic offer(input logic [11:0] d);
      valid = 1'b1;
      data  = d;
   endtask
   task automatic model_reset();
      k = 0; m_disp = '0; m_pend = '0; m_full = 1'b0;
   endtask
   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sel", sel, 4'hF);
      check("rst_val", val, 3'd0);
      check("rst_ready", ready, 1'b1);
      check("rst_done", done, 1'b0);
      rst_n = 1'b1;
      model_reset();
      repeat (FRAME) tick();
      repeat (7) tick();
      offer(12'o7531);
      repeat (2 * FRAME) tick();
      offer(12'o1234);
      tick();
      offer(12'o6420);
      for (int i = 0; i < 3 * FRAME && valid; i++) tick();
      check("reoffer_taken", valid, 1'b0);
      repeat (2 * FRAME) tick();
      for (int i = 0; i < 4 * FRAME && !(k % FRAME == FRAME - 1 && !m_full && !valid); i++) tick();
      check("bnd_pos", k % FRAME, FRAME - 1);
      offer(12'o3333);
      tick();
      check("bnd_ready", ready, 1'b0);
      check("bnd_hold", done, 1'b1);
      repeat (2 * FRAME) tick();
      for (int i = 0; i < 2 * FRAME && k % FRAME != 2 * SLOT + 2; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_sel", sel, 4'hF);
      check("arst_val", val, 3'd0);
      check("arst_ready", ready, 1'b1);
      check("arst_done", done, 1'b0);
      valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      check_all();
      repeat (FRAME) tick();
      offer(12'o0030);
      repeat (3 * FRAME) tick();
      offer(12'o0000);
      repeat (3 * FRAME) tick();
      for (int i = 0; i < 500; i++) begin
         if (!valid && $urandom_range(0, 7) == 0)
            offer(($urandom_range(0, 3) == 0) ? 12'(($urandom_range(0, 7)) << (3 * $urandom_range(0, 3))) : 12'($urandom));
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
